// File: rtl/kseq_pkg.sv
// kseq_pkg: shared state encoding, hold-mode constant and period lookup
// for kernel_sequencer and its pass counter.
package kseq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [1:0] MODE_HOLD = 2'd3;

    // Last counter value of a pass for a kernel mode; HOLD has no pass.
    function automatic int period_of(
        input logic [1:0] mode,
        input int         p0,
        input int         p1,
        input int         p2
    );
        int p;
        case (mode)
            2'd0:    p = p0;
            2'd1:    p = p1;
            2'd2:    p = p2;
            default: p = 0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/kseq_pass_counter.sv
// kseq_pass_counter: intra-pass cycle counter, completed-pass counter and
// latched pass target, with stall hold and layer-terminal detect.
// Ports:
//   clk, rst_n       falling-edge clock, async active-low reset
//   clr              synchronous clear (highest priority)
//   load             accepted start: zero counters, latch target
//   run              sequencer is in RUN
//   stall            freeze counting while in RUN
//   period           last cnt value of a pass for the latched mode
//   target           pass target, sampled on load (0 becomes 1)
//   cnt_nxt          cnt value for the next cycle
//   pass_cnt         completed passes in the current layer
//   layer_end        this edge completes the final pass
module kseq_pass_counter #(
    parameter int CNT_W  = 7,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              load,
    input  logic              run,
    input  logic              stall,
    input  logic [CNT_W-1:0]  period,
    input  logic [PASS_W-1:0] target,
    output logic [CNT_W-1:0]  cnt_nxt,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              layer_end
);

    logic [CNT_W-1:0]  cnt;
    logic [PASS_W-1:0] tgt;
    logic [PASS_W-1:0] tgt_nxt;
    logic [PASS_W-1:0] pass_nxt;
    logic [PASS_W-1:0] pass_inc;
    logic              advance;
    logic              last;

    assign advance   = run & ~stall & ~clr;
    assign last      = (cnt == period);
    // Saturating increment so the count can never wrap past all-ones.
    assign pass_inc  = (pass_cnt == '1) ? pass_cnt
                                        : pass_cnt + PASS_W'(1);
    assign layer_end = advance & last & (pass_inc == tgt);

    always_comb begin
        cnt_nxt  = cnt;
        pass_nxt = pass_cnt;
        tgt_nxt  = tgt;
        if (clr) begin
            cnt_nxt  = '0;
            pass_nxt = '0;
        end else if (load) begin
            cnt_nxt  = '0;
            pass_nxt = '0;
            tgt_nxt  = (target == '0) ? PASS_W'(1) : target;
        end else if (advance) begin
            if (last) begin
                cnt_nxt  = '0;
                pass_nxt = pass_inc;
            end else begin
                cnt_nxt  = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            pass_cnt <= '0;
            tgt      <= '0;
        end else begin
            cnt      <= cnt_nxt;
            pass_cnt <= pass_nxt;
            tgt      <= tgt_nxt;
        end
    end

endmodule

// File: rtl/kernel_sequencer.sv
// kernel_sequencer: per-layer kernel pass sequencer driving the conv PE
// array input/feedback muxes. State updates on the falling CLK edge.
// Ports:
//   CLK, RESET_N     clock, async active-low reset
//   clr              sync clear back to IDLE
//   start            begin a layer (IDLE/HOLD only)
//   mode_sel         kernel mode 0..2, 3 = HOLD
//   dbg_en/dbg_mode  debug override of mode_sel at start
//   pass_target      passes per layer (0 treated as 1)
//   stall            downstream not ready, freezes RUN
//   input_flag       PE array loads fresh input
//   feedback_flag    PE array recirculates accumulator
//   period_last      final cycle of the current pass
//   layer_done       pulse after the last pass
//   busy             high in RUN
//   cur_mode         latched effective mode
//   pass_cnt         completed passes this layer
//   stall_cycles     stalled RUN cycles (only with KSEQ_STALL_PERF_EN)
module kernel_sequencer
    import kseq_pkg::*;
#(
    parameter int CNT_W   = 7,
    parameter int PASS_W  = 8,
    parameter int PERIOD0 = 8,
    parameter int PERIOD1 = 32,
    parameter int PERIOD2 = 127
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              clr,
    input  logic              start,
    input  logic [1:0]        mode_sel,
    input  logic              dbg_en,
    input  logic [1:0]        dbg_mode,
    input  logic [PASS_W-1:0] pass_target,
    input  logic              stall,
    output logic              input_flag,
    output logic              feedback_flag,
    output logic              period_last,
    output logic              layer_done,
    output logic              busy,
    output logic [1:0]        cur_mode,
    output logic [PASS_W-1:0] pass_cnt
`ifdef KSEQ_STALL_PERF_EN
    ,
    output logic [31:0]       stall_cycles
`endif
);

    if (PERIOD0 >= (1 << CNT_W) || PERIOD1 >= (1 << CNT_W) ||
        PERIOD2 >= (1 << CNT_W)) begin : g_period_check
        $error("kernel_sequencer: a PERIOD does not fit in CNT_W bits");
    end

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        eff_mode;
    logic [1:0]        mode_nxt;
    logic              accept;
    logic              in_run;
    logic              stall_cyc;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cur_period;
    logic [CNT_W-1:0]  nxt_period;
    logic              layer_end;
    logic              run_go;
    logic              input_flag_d;
    logic              feedback_flag_d;
    logic              period_last_d;
    logic              layer_done_d;
    logic              busy_d;

    assign eff_mode  = dbg_en ? dbg_mode : mode_sel;
    assign in_run    = (state == RUN);
    assign accept    = start & ~clr & (state == IDLE || state == HOLD);
    assign stall_cyc = in_run & stall & ~clr;
    assign mode_nxt  = accept ? eff_mode : cur_mode;

    assign cur_period = CNT_W'(period_of(cur_mode, PERIOD0, PERIOD1, PERIOD2));
    assign nxt_period = CNT_W'(period_of(mode_nxt, PERIOD0, PERIOD1, PERIOD2));

    kseq_pass_counter #(
        .CNT_W  (CNT_W),
        .PASS_W (PASS_W)
    ) u_pass_counter (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .clr       (clr),
        .load      (accept),
        .run       (in_run),
        .stall     (stall),
        .period    (cur_period),
        .target    (pass_target),
        .cnt_nxt   (cnt_nxt),
        .pass_cnt  (pass_cnt),
        .layer_end (layer_end)
    );

    // State and output registers. Flags are registered from next-cycle
    // values so they line up with the cnt they decode.
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            cur_mode      <= '0;
            input_flag    <= 1'b0;
            feedback_flag <= 1'b0;
            period_last   <= 1'b0;
            layer_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cur_mode      <= mode_nxt;
            input_flag    <= input_flag_d;
            feedback_flag <= feedback_flag_d;
            period_last   <= period_last_d;
            layer_done    <= layer_done_d;
            busy          <= busy_d;
        end
    end

    always_comb begin
        state_nxt = state;
        if (clr) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = (eff_mode == MODE_HOLD) ? HOLD : RUN;
        end else if (in_run && layer_end) begin
            state_nxt = IDLE;
        end
    end

    // A stalled RUN cycle shows no flags; the held cnt replays afterwards.
    always_comb begin
        run_go          = (state_nxt == RUN) & ~stall_cyc;
        input_flag_d    = run_go & (cnt_nxt == '0);
        feedback_flag_d = (run_go & (cnt_nxt != '0)) | (state_nxt == HOLD);
        period_last_d   = run_go & (cnt_nxt == nxt_period);
        layer_done_d    = layer_end;
        busy_d          = (state_nxt == RUN);
    end

`ifdef KSEQ_STALL_PERF_EN
    always_ff @(negedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stall_cycles <= '0;
        end else if (clr || accept) begin
            stall_cycles <= '0;
        end else if (stall_cyc && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// tb_kernel_sequencer: directed and randomized checks of kernel_sequencer
// against a queue-based pass schedule model.
module tb_kernel_sequencer;

    localparam int PASS_W = 8;
    localparam int P0 = 8;
    localparam int P1 = 32;
    localparam int P2 = 127;

    logic              CLK = 1'b0;
    logic              RESET_N = 1'b1;
    logic              clr = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode_sel = '0;
    logic              dbg_en = 1'b0;
    logic [1:0]        dbg_mode = '0;
    logic [PASS_W-1:0] pass_target = '0;
    logic              stall = 1'b0;
    logic              input_flag;
    logic              feedback_flag;
    logic              period_last;
    logic              layer_done;
    logic              busy;
    logic [1:0]        cur_mode;
    logic [PASS_W-1:0] pass_cnt;
`ifdef KSEQ_STALL_PERF_EN
    logic [31:0]       stall_cycles;
`endif

    kernel_sequencer #(
        .CNT_W   (7),
        .PASS_W  (PASS_W),
        .PERIOD0 (P0),
        .PERIOD1 (P1),
        .PERIOD2 (P2)
    ) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .clr           (clr),
        .start         (start),
        .mode_sel      (mode_sel),
        .dbg_en        (dbg_en),
        .dbg_mode      (dbg_mode),
        .pass_target   (pass_target),
        .stall         (stall),
        .input_flag    (input_flag),
        .feedback_flag (feedback_flag),
        .period_last   (period_last),
        .layer_done    (layer_done),
        .busy          (busy),
        .cur_mode      (cur_mode),
        .pass_cnt      (pass_cnt)
`ifdef KSEQ_STALL_PERF_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a layer is a list of scheduled cycles, one entry per pass cycle.
    typedef struct packed {
        bit in_f;
        bit fb;
        bit last;
    } item_t;

    item_t  q[$];
    item_t  m_cur;
    int     m_st;       // 0 idle, 1 run, 2 hold
    int     m_mode;
    int     m_pass;
    bit     m_done;
    bit     m_stalled;
    longint m_stalls;

    function automatic int period(input int m);
        return (m == 0) ? P0 : (m == 1) ? P1 : P2;
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                       input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input logic obs, input bit exp, input string tag);
        chk(32'(obs), 32'(exp), tag);
    endtask

    task automatic model_reset();
        m_st = 0;
        q.delete();
        m_cur = '0;
        m_mode = 0;
        m_pass = 0;
        m_done = 0;
        m_stalled = 0;
        m_stalls = 0;
    endtask

    task automatic model_step(input bit c, input bit s, input bit st,
                              input int em, input int tgt);
        int t;
        int p;
        m_done = 0;
        m_stalled = 0;
        if (c) begin
            m_st = 0;
            q.delete();
            m_pass = 0;
            m_stalls = 0;
        end else if (s && m_st != 1) begin
            m_mode = em;
            m_pass = 0;
            m_stalls = 0;
            q.delete();
            if (em == 3) begin
                m_st = 2;
            end else begin
                t = (tgt == 0) ? 1 : tgt;
                p = period(em);
                for (int n = 0; n < t; n++)
                    for (int k = 0; k <= p; k++)
                        q.push_back('{k == 0, k != 0, k == p});
                m_st = 1;
                m_cur = q.pop_front();
            end
        end else if (m_st == 1 && st) begin
            m_stalled = 1;
            m_stalls++;
        end else if (m_st == 1) begin
            if (m_cur.last) m_pass++;
            if (q.size() == 0) begin
                m_st = 0;
                m_done = 1;
            end else begin
                m_cur = q.pop_front();
            end
        end
    endtask

    task automatic model_check(input string tag);
        logic [14:0] obs;
        logic [14:0] exp;
        bit          act;
        act = (m_st == 1) && !m_stalled;
        obs = {input_flag, feedback_flag, period_last, layer_done, busy,
               cur_mode, pass_cnt};
        exp = {act & m_cur.in_f, (act & m_cur.fb) | (m_st == 2),
               act & m_cur.last, m_done, m_st == 1, 2'(m_mode),
               PASS_W'(m_pass)};
        chk(32'(obs), 32'(exp), tag);
`ifdef KSEQ_STALL_PERF_EN
        chk(stall_cycles, 32'(m_stalls), {tag, "_stalls"});
`endif
    endtask

    task automatic go(input int ms, input bit de, input int dm,
                      input int tgt, input string tag);
        clr = 0;
        start = 1;
        stall = 0;
        mode_sel = 2'(ms);
        dbg_en = de;
        dbg_mode = 2'(dm);
        pass_target = PASS_W'(tgt);
        model_step(0, 1, 0, de ? dm : ms, tgt);
        @(posedge CLK);
        model_check(tag);
    endtask

    task automatic tick(input bit c, input bit s, input bit st,
                        input string tag);
        clr = c;
        start = s;
        stall = st;
        model_step(c, s, st, dbg_en ? int'(dbg_mode) : int'(mode_sel),
                   int'(pass_target));
        @(posedge CLK);
        model_check(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 RESET_N = 1'b0;
        #1 model_reset();
        model_check(tag);
        @(posedge CLK);
        RESET_N = 1'b1;
        clr = 0;
        start = 0;
        stall = 0;
    endtask

    initial begin
        do_reset("reset");

        // Mode 0, two passes.
        go(0, 0, 0, 2, "t1_start");
        chk1(input_flag, 1, "t1_in_c1");
        for (int i = 2; i <= 21; i++) begin
            tick(0, 0, 0, "t1");
            chk1(input_flag, i == 10, "t1_in");
            chk1(feedback_flag, i <= 18 && i != 10, "t1_fb");
            chk1(period_last, i == 9 || i == 18, "t1_last");
            chk1(layer_done, i == 19, "t1_done");
        end
        chk(32'(pass_cnt), 2, "t1_pass");

        // Mode 2 with a five-cycle stall at cnt 40.
        go(2, 0, 0, 1, "t2_start");
        for (int i = 2; i <= 135; i++) begin
            tick(0, 0, i >= 42 && i <= 46, "t2");
            if (i >= 42 && i <= 46)
                chk(32'({input_flag, feedback_flag, period_last}), 0,
                    "t2_stall_flags");
            chk1(period_last, i == 133, "t2_last");
            chk1(layer_done, i == 134, "t2_done");
        end
`ifdef KSEQ_STALL_PERF_EN
        chk(stall_cycles, 5, "t2_stall_cycles");
`endif

        // Debug override: mode 1, three passes.
        go(0, 1, 1, 3, "t3_start");
        chk(32'(cur_mode), 1, "t3_mode");
        for (int i = 2; i <= 101; i++) begin
            tick(0, 0, 0, "t3");
            chk1(period_last, i == 33 || i == 66 || i == 99, "t3_last");
            chk1(layer_done, i == 100, "t3_done");
        end
        dbg_en = 0;

        // HOLD, then a direct restart in mode 0.
        go(3, 0, 0, 1, "t4_hold");
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, "t4");
            chk1(input_flag, 0, "t4_in");
            chk1(feedback_flag, 1, "t4_fb");
        end
        go(0, 0, 0, 1, "t4_restart");
        chk1(input_flag, 1, "t4_restart_in");
        for (int i = 2; i <= 10; i++) tick(0, 0, 0, "t4_run");

        // Clear at cnt 15 in mode 1, then async reset mid-RUN.
        go(1, 0, 0, 1, "t5_start");
        for (int i = 2; i <= 16; i++) tick(0, 0, 0, "t5");
        tick(1, 0, 0, "t5_clr");
        chk1(busy, 0, "t5_busy");
        chk(32'(pass_cnt), 0, "t5_pass");
        for (int i = 0; i < 3; i++) tick(0, 0, 0, "t5_after");
        go(1, 0, 0, 2, "t5_restart");
        for (int i = 0; i < 5; i++) tick(0, 0, 0, "t5_run");
        do_reset("t5_reset");

        // Target 0 behaves as one pass.
        go(0, 0, 0, 0, "t6_start");
        for (int i = 2; i <= 11; i++) begin
            tick(0, 0, 0, "t6");
            chk1(period_last, i == 9, "t6_last");
            chk1(layer_done, i == 10, "t6_done");
        end
        chk(32'(pass_cnt), 1, "t6_pass");

        // Randomized layers with stalls, stray starts and rare clears.
        for (int l = 0; l < 10; l++) begin
            int md;
            int tg;
            int k;
            md = int'($urandom_range(0, 3));
            tg = int'($urandom_range(0, 3));
            if (md == 2 && tg > 2) tg = 2;
            go(md, 0, 0, tg, "rnd_start");
            if (m_st == 2) begin
                for (int h = 0; h < 10; h++) tick(0, 0, 0, "rnd_hold");
            end else begin
                k = 0;
                while (m_st == 1 && k < 700) begin
                    tick($urandom_range(0, 299) == 0,
                         $urandom_range(0, 19) == 0,
                         $urandom_range(0, 5) == 0, "rnd");
                    k++;
                end
                chk(32'(m_st), 0, "rnd_budget");
                tick(0, 0, 0, "rnd_idle");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
